// File: rtl/capture_ctrl.sv
// Capture sequencer: IDLE -> CLEAR -> PRE -> ARMED -> POST -> READ -> CLEAR, with abort and continuous re-arm.
// Optional ARMED forced-trigger timeout is enabled by defining CAPTURE_CTRL_TIMEOUT_EN.
module capture_ctrl #(
    parameter int CNT_W          = 16,
    parameter int CLR_CYCLES     = 11,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SampleEN,
    input  logic             Arm,
    input  logic             Abort,
    input  logic             Mode,
    input  logic [CNT_W-1:0] PreCount,
    input  logic [CNT_W-1:0] PostCount,
    input  logic             Trig,
    input  logic             almostfull,
    input  logic             FinishRD,
    output logic             ENWFIFO,
    output logic             ENTrig,
    output logic             ENOUT,
    output logic             ClrFIFO,
    output logic             DropOld,
    output logic             Done,
    output logic             Busy,
    output logic [2:0]       state,
    output logic             TimedOut
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PRE   = 3'd2,
        ST_ARMED = 3'd3,
        ST_POST  = 3'd4,
        ST_READ  = 3'd5
    } state_t;

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               rearm_q, rearm_d;
    logic               pending_q, pending_d;
    logic               done_d;
    logic [CNT_W-1:0]   cnt_acc;
    logic               enwfifo_q, entrig_q, enout_q, clrfifo_q, dropold_q, done_q, busy_q;

`ifdef CAPTURE_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               timed_out_q, timed_out_d;
`endif

    // Saturating sample count including this cycle's strobe.
    assign cnt_acc = (SampleEN && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pre_d     = pre_q;
        post_d    = post_q;
        clr_cnt_d = clr_cnt_q;
        rearm_d   = rearm_q;
        pending_d = pending_q;
        done_d    = 1'b0;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
        to_cnt_d    = '0;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Arm) begin
                    pre_d     = PreCount;
                    post_d    = PostCount;
                    rearm_d   = Mode;
                    pending_d = 1'b1;
                    clr_cnt_d = '0;
                    state_d   = ST_CLEAR;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
                    timed_out_d = 1'b0;
`endif
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                    clr_cnt_d = '0;
                    cnt_d     = '0;
                    if ((rearm_q || pending_q) && !Abort) begin
                        pending_d = 1'b0;
                        state_d   = ST_PRE;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_PRE: begin
                cnt_d = cnt_acc;
                if (pre_q == '0 || cnt_acc == pre_q)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
`ifdef CAPTURE_CTRL_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 1'b1;
`endif
                if (Trig) begin
                    cnt_d   = '0;
                    state_d = ST_POST;
                end
`ifdef CAPTURE_CTRL_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt_d       = '0;
                    timed_out_d = 1'b1;
                    state_d     = ST_POST;
                end
`endif
            end
            ST_POST: begin
                cnt_d = cnt_acc;
                if (post_q == '0 || cnt_acc == post_q || almostfull)
                    state_d = ST_READ;
            end
            ST_READ: begin
                if (FinishRD) begin
                    done_d    = 1'b1;
                    rearm_d   = Mode ? rearm_q : 1'b0;
                    clr_cnt_d = '0;
                    state_d   = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over every other event; an ongoing clear keeps its count.
        if (Abort && state_q != ST_IDLE) begin
            rearm_d   = 1'b0;
            pending_d = 1'b0;
            done_d    = 1'b0;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
            timed_out_d = timed_out_q;
`endif
            if (state_q != ST_CLEAR) begin
                clr_cnt_d = '0;
                state_d   = ST_CLEAR;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            clr_cnt_q <= '0;
            rearm_q   <= 1'b0;
            pending_q <= 1'b0;
            enwfifo_q <= 1'b0;
            entrig_q  <= 1'b0;
            enout_q   <= 1'b0;
            clrfifo_q <= 1'b0;
            dropold_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            post_q    <= post_d;
            clr_cnt_q <= clr_cnt_d;
            rearm_q   <= rearm_d;
            pending_q <= pending_d;
            // Outputs decode the next state so they line up with state_q.
            enwfifo_q <= (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
            entrig_q  <= (state_d == ST_ARMED);
            enout_q   <= (state_d == ST_READ);
            clrfifo_q <= (state_d == ST_CLEAR);
            dropold_q <= (state_d == ST_ARMED) && almostfull && SampleEN;
            done_q    <= done_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

`ifdef CAPTURE_CTRL_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end
    assign TimedOut = timed_out_q;
`else
    assign TimedOut = 1'b0;
`endif

    assign ENWFIFO = enwfifo_q;
    assign ENTrig  = entrig_q;
    assign ENOUT   = enout_q;
    assign ClrFIFO = clrfifo_q;
    assign DropOld = dropold_q;
    assign Done    = done_q;
    assign Busy    = busy_q;
    assign state   = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl (CLR_CYCLES=11, TIMEOUT_CYCLES=20).
`timescale 1ns/1ps
module tb_capture_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             sample_en, arm, abort_i, mode, trig, almostfull, finish_rd;
    logic [CNT_W-1:0] pre_count, post_count;
    logic             enwfifo, entrig, enout, clrfifo, dropold, done, busy, timed_out;
    logic [2:0]       state;

    int n_cmp  = 0;
    int n_fail = 0;

    capture_ctrl #(
        .CNT_W(CNT_W),
        .CLR_CYCLES(11),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .CLK(clk), .RST(rst), .SampleEN(sample_en), .Arm(arm), .Abort(abort_i),
        .Mode(mode), .PreCount(pre_count), .PostCount(post_count), .Trig(trig),
        .almostfull(almostfull), .FinishRD(finish_rd), .ENWFIFO(enwfifo),
        .ENTrig(entrig), .ENOUT(enout), .ClrFIFO(clrfifo), .DropOld(dropold),
        .Done(done), .Busy(busy), .state(state), .TimedOut(timed_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of consecutive cycles spent in s, counting the current one.
    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (state == s && n < 500) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_state(input logic [2:0] s);
        int k = 0;
        while (state != s && k < 300) begin
            k++;
            tick();
        end
        n_cmp++;
        if (state !== s) begin
            n_fail++;
            $display("FAIL wait_state: state=%0d required %0d", state, s);
        end
    endtask

    task automatic start(input logic m, input int pre, input int post);
        mode       = m;
        pre_count  = CNT_W'(pre);
        post_count = CNT_W'(post);
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({state, enwfifo, entrig, enout, clrfifo, dropold, done, busy, timed_out} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset: state=%0d outs=%b required 0/00000000", state,
                     {enwfifo, entrig, enout, clrfifo, dropold, done, busy, timed_out});
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single();
        int n;
        sample_en = 1'b1;
        start(1'b0, 4, 3);
        n_cmp++;
        if (state !== 3'd1 || clrfifo !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_clear_entry: state=%0d clr=%b busy=%b required 1/1/1", state, clrfifo, busy);
        end
        count_state(3'd1, n);
        n_cmp++;
        if (n != 11) begin n_fail++; $display("FAIL single_clear_len: %0d required 11", n); end
        n_cmp++;
        if (state !== 3'd2 || enwfifo !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pre_entry: state=%0d enw=%b required 2/1", state, enwfifo);
        end
        count_state(3'd2, n);
        n_cmp++;
        if (n != 4) begin n_fail++; $display("FAIL single_pre_len: %0d required 4", n); end
        repeat (9) tick();
        n_cmp++;
        if (state !== 3'd3 || entrig !== 1'b1 || enwfifo !== 1'b1) begin
            n_fail++;
            $display("FAIL single_armed: state=%0d entrig=%b enw=%b required 3/1/1", state, entrig, enwfifo);
        end
        trig = 1'b1;
        tick();
        trig = 1'b0;
        n_cmp++;
        if (state !== 3'd4 || entrig !== 1'b0) begin
            n_fail++;
            $display("FAIL single_post_entry: state=%0d entrig=%b required 4/0", state, entrig);
        end
        count_state(3'd4, n);
        n_cmp++;
        if (n != 3) begin n_fail++; $display("FAIL single_post_len: %0d required 3", n); end
        n_cmp++;
        if (state !== 3'd5 || enout !== 1'b1 || enwfifo !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read: state=%0d enout=%b enw=%b required 5/1/0", state, enout, enwfifo);
        end
        finish_rd = 1'b1;
        tick();
        finish_rd = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL single_done: done=%b state=%0d required 1/1", done, state);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: done=%b required 0", done); end
        count_state(3'd1, n);
        n_cmp++;
        if (n + 1 != 11 || state !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_final: clear=%0d state=%0d busy=%b required 11/0/0", n + 1, state, busy);
        end
        $display("test_single done");
    endtask

    task automatic run_to_read();
        wait_state(3'd3);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_state(3'd5);
    endtask

    task automatic test_continuous();
        int n;
        sample_en = 1'b1;
        start(1'b1, 2, 2);
        run_to_read();
        finish_rd = 1'b1;
        tick();
        finish_rd = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL cont_done1: done=%b state=%0d required 1/1", done, state);
        end
        count_state(3'd1, n);
        n_cmp++;
        if (state !== 3'd2) begin n_fail++; $display("FAIL cont_rearm: state=%0d required 2", state); end
        run_to_read();
        mode      = 1'b0;
        finish_rd = 1'b1;
        tick();
        finish_rd = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL cont_done2: done=%b state=%0d required 1/1", done, state);
        end
        count_state(3'd1, n);
        n_cmp++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL cont_end_idle: state=%0d required 0", state); end
        $display("test_continuous done");
    endtask

    task automatic test_dropold();
        logic se;
        start(1'b0, 1, 5);
        wait_state(3'd3);
        almostfull = 1'b1;
        for (int i = 0; i < 6; i++) begin
            se        = (i % 2 == 0);
            sample_en = se;
            tick();
            n_cmp++;
            if (dropold !== se || enwfifo !== 1'b1 || state !== 3'd3) begin
                n_fail++;
                $display("FAIL dropold[%0d]: drop=%b enw=%b state=%0d required %b/1/3", i, dropold, enwfifo, state, se);
            end
        end
        almostfull = 1'b0;
        sample_en  = 1'b1;
        abort_i    = 1'b1;
        tick();
        abort_i    = 1'b0;
        n_cmp++;
        if (state !== 3'd1 || dropold !== 1'b0) begin
            n_fail++;
            $display("FAIL dropold_abort: state=%0d drop=%b required 1/0", state, dropold);
        end
        wait_state(3'd0);
        $display("test_dropold done");
    endtask

    task automatic test_zero_counts();
        int n;
        sample_en = 1'b1;
        start(1'b0, 0, 0);
        wait_state(3'd2);
        count_state(3'd2, n);
        n_cmp++;
        if (n != 1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL zero_pre: len=%0d state=%0d required 1/3", n, state);
        end
        trig = 1'b1;
        tick();
        trig = 1'b0;
        count_state(3'd4, n);
        n_cmp++;
        if (n != 1 || state !== 3'd5) begin
            n_fail++;
            $display("FAIL zero_post: len=%0d state=%0d required 1/5", n, state);
        end
        finish_rd = 1'b1;
        tick();
        finish_rd = 1'b0;
        wait_state(3'd0);
        start(1'b0, 0, 100);
        wait_state(3'd3);
        trig = 1'b1;
        tick();
        trig       = 1'b0;
        almostfull = 1'b1;
        tick();
        almostfull = 1'b0;
        n_cmp++;
        if (state !== 3'd5) begin n_fail++; $display("FAIL early_stop: state=%0d required 5", state); end
        finish_rd = 1'b1;
        tick();
        finish_rd = 1'b0;
        wait_state(3'd0);
        $display("test_zero_counts done");
    endtask

    task automatic test_abort();
        int n;
        sample_en = 1'b1;
        start(1'b1, 1, 2);
        wait_state(3'd3);
        trig    = 1'b1;
        abort_i = 1'b1;
        tick();
        trig    = 1'b0;
        abort_i = 1'b0;
        n_cmp++;
        if (state !== 3'd1 || clrfifo !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_vs_trig: state=%0d clr=%b required 1/1", state, clrfifo);
        end
        repeat (4) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        count_state(3'd1, n);
        n_cmp++;
        if (n + 5 != 11 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_clear: len=%0d state=%0d required 11/0", n + 5, state);
        end
        start(1'b0, 1, 50);
        run_to_read_post();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({state, enwfifo, entrig, enout, clrfifo, dropold, done, busy} !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d outs=%b required 0/0000000", state,
                     {enwfifo, entrig, enout, clrfifo, dropold, done, busy});
        end
        #1 rst = 1'b0;
        tick();
        $display("test_abort done");
    endtask

    task automatic run_to_read_post();
        wait_state(3'd3);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        n_cmp++;
        if (state !== 3'd4 || enwfifo !== 1'b1) begin
            n_fail++;
            $display("FAIL post_before_reset: state=%0d enw=%b required 4/1", state, enwfifo);
        end
    endtask

    task automatic test_timeout();
        int n;
        sample_en = 1'b1;
        start(1'b0, 1, 2);
        wait_state(3'd3);
`ifdef CAPTURE_CTRL_TIMEOUT_EN
        count_state(3'd3, n);
        n_cmp++;
        if (n != 20 || state !== 3'd4 || timed_out !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_fire: armed=%0d state=%0d to=%b required 20/4/1", n, state, timed_out);
        end
        wait_state(3'd5);
        finish_rd = 1'b1;
        tick();
        finish_rd = 1'b0;
        wait_state(3'd0);
        n_cmp++;
        if (timed_out !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: to=%b required 1", timed_out); end
        start(1'b0, 1, 2);
        n_cmp++;
        if (timed_out !== 1'b0 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL timeout_clear: to=%b state=%0d required 0/1", timed_out, state);
        end
`else
        n = 0;
        repeat (30) tick();
        n_cmp++;
        if (state !== 3'd3 || timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: state=%0d to=%b required 3/0", state, timed_out);
        end
`endif
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_state(3'd0);
        $display("test_timeout done");
    endtask

    initial begin
        rst        = 1'b1;
        sample_en  = 1'b0;
        arm        = 1'b0;
        abort_i    = 1'b0;
        mode       = 1'b0;
        trig       = 1'b0;
        almostfull = 1'b0;
        finish_rd  = 1'b0;
        pre_count  = '0;
        post_count = '0;
        test_reset();
        test_single();
        test_continuous();
        test_dropold();
        test_zero_counts();
        test_abort();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
